camera_ctrl_fsm: RTL and testbench

Top-level sequencer for the digital camera core. Accepts user buttons (init, exposure up/down), holds the exposure-time register, drives the exposure timer counter (clear/start, watches its overflow), and generates the pixel-array control strobes (erase, expose, two-row readout with ADC strobes). It sits between the button inputs and the exposure timer and pixel array.

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_readout_seq.sv | 62 ++++++
 rtl/camera_ctrl_fsm.sv | 121 ++++++++++++
 tb/tb_camera_ctrl_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// ============================================================================
// Module   : cam_pkg
// Brief    : Shared types and constants for the camera control core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

    localparam int C_EXP_W = 5;

    localparam logic [C_EXP_W-1:0] C_EXP_MIN   = 5'd2;
    localparam logic [C_EXP_W-1:0] C_EXP_MAX   = 5'd30;
    localparam logic [C_EXP_W-1:0] C_EXP_RESET = 5'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        EXPOSE = 2'd2,
        READ   = 2'd3
    } cam_state_t;

endpackage

`default_nettype wire

// File: rtl/cam_readout_seq.sv
// ============================================================================
// Module   : cam_readout_seq
// Brief    : Eight-step two-row readout sequencer with registered nre/adc strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_readout_seq
    import cam_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic go,
    output logic done,
    output logic nre_1,
    output logic nre_2,
    output logic adc
);

    logic       r_active;
    logic       w_active_n;
    logic [2:0] r_step;
    logic [2:0] w_step_n;

    always_comb begin
        w_active_n = r_active;
        w_step_n   = r_step;
        if (go) begin
            w_active_n = 1'b1;
            w_step_n   = 3'd0;
        end else if (r_active) begin
            if (r_step == 3'd7) begin
                w_active_n = 1'b0;
                w_step_n   = 3'd0;
            end else begin
                w_step_n = r_step + 3'd1;
            end
        end
    end

    // Strobes are decoded from the next step so they line up with the step register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_step   <= 3'd0;
            nre_1    <= 1'b1;
            nre_2    <= 1'b1;
            adc      <= 1'b0;
        end else begin
            r_active <= w_active_n;
            r_step   <= w_step_n;
            nre_1    <= !(w_active_n && (w_step_n <= 3'd2));
            nre_2    <= !(w_active_n && (w_step_n >= 3'd4) && (w_step_n <= 3'd6));
            adc      <= w_active_n && ((w_step_n == 3'd1) || (w_step_n == 3'd5));
        end
    end

    assign done = r_active && (r_step == 3'd7);

endmodule

`default_nettype wire

// File: rtl/camera_ctrl_fsm.sv
// ============================================================================
// Module   : camera_ctrl_fsm
// Brief    : Camera sequencer: buttons, exposure register, timer and pixel strobes.
//            CAM_CONT_EN selects continuous capture while init is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module camera_ctrl_fsm
    import cam_pkg::*;
#(
    parameter logic [C_EXP_W-1:0] EXP_MIN   = C_EXP_MIN,
    parameter logic [C_EXP_W-1:0] EXP_MAX   = C_EXP_MAX,
    parameter logic [C_EXP_W-1:0] EXP_RESET = C_EXP_RESET
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               exp_increase,
    input  logic               exp_decrease,
    input  logic               ovf5,
    output logic [C_EXP_W-1:0] ex_time,
    output logic               timer_clr,
    output logic               timer_start,
    output logic               erase,
    output logic               expose,
    output logic               nre_1,
    output logic               nre_2,
    output logic               adc,
    output logic               busy
);

    cam_state_t r_state;
    cam_state_t w_state_n;
    logic       r_inc_q;
    logic       r_dec_q;
    logic       r_init_q;
    logic       w_inc_edge;
    logic       w_dec_edge;
    logic       w_capture;
    logic       w_adj_ok;
    logic       w_go;
    logic       w_done;

    assign w_inc_edge = exp_increase & ~r_inc_q;
    assign w_dec_edge = exp_decrease & ~r_dec_q;
    assign w_adj_ok   = (r_state == IDLE) && !init;

`ifdef CAM_CONT_EN
    assign w_capture = init;
`else
    assign w_capture = init & ~r_init_q;
`endif

    always_comb begin
        w_state_n = r_state;
        w_go      = 1'b0;
        case (r_state)
            IDLE:   if (w_capture) w_state_n = ARM;
            ARM:    w_state_n = EXPOSE;
            // timer_start marks the first EXPOSE cycle, where a stale ovf5 is ignored.
            EXPOSE: if (!timer_start && ovf5) begin
                        w_state_n = READ;
                        w_go      = 1'b1;
                    end
            READ:   if (w_done) begin
`ifdef CAM_CONT_EN
                        w_state_n = init ? ARM : IDLE;
`else
                        w_state_n = IDLE;
`endif
                    end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_inc_q     <= 1'b0;
            r_dec_q     <= 1'b0;
            r_init_q    <= 1'b0;
            ex_time     <= EXP_RESET;
            timer_clr   <= 1'b0;
            timer_start <= 1'b0;
            erase       <= 1'b1;
            expose      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_inc_q     <= exp_increase;
            r_dec_q     <= exp_decrease;
            r_init_q    <= init;
            if (w_adj_ok && (w_inc_edge ^ w_dec_edge)) begin
                if (w_inc_edge && (ex_time < EXP_MAX))
                    ex_time <= ex_time + 5'd1;
                else if (w_dec_edge && (ex_time > EXP_MIN))
                    ex_time <= ex_time - 5'd1;
            end
            timer_clr   <= (w_state_n == ARM);
            timer_start <= (r_state == ARM) && (w_state_n == EXPOSE);
            erase       <= (w_state_n == IDLE);
            expose      <= (w_state_n == EXPOSE);
            busy        <= (w_state_n != IDLE);
        end
    end

    cam_readout_seq u_readout (
        .clk   (clk),
        .reset (reset),
        .go    (w_go),
        .done  (w_done),
        .nre_1 (nre_1),
        .nre_2 (nre_2),
        .adc   (adc)
    );

endmodule

`default_nettype wire

// File: tb/tb_camera_ctrl_fsm.sv
// ============================================================================
// Module   : tb_camera_ctrl_fsm
// Brief    : Directed self-checking bench for camera_ctrl_fsm (CAM_CONT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_camera_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic       exp_increase;
    logic       exp_decrease;
    logic       ovf5;
    logic [4:0] ex_time;
    logic       timer_clr;
    logic       timer_start;
    logic       erase;
    logic       expose;
    logic       nre_1;
    logic       nre_2;
    logic       adc;
    logic       busy;
    logic [7:0] w_outs;

    int checks = 0;
    int errors = 0;

    // Output vector order: erase expose nre_1 nre_2 adc busy timer_clr timer_start
    localparam logic [7:0] C_O_IDLE = 8'b1011_0000;
    localparam logic [7:0] C_O_ARM  = 8'b0011_0110;
    localparam logic [7:0] C_O_EXP1 = 8'b0111_0101;
    localparam logic [7:0] C_O_EXP  = 8'b0111_0100;

    logic [7:0] c_read [8];

    always #5 clk = ~clk;

    assign w_outs = {erase, expose, nre_1, nre_2, adc, busy, timer_clr, timer_start};

    camera_ctrl_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .exp_increase (exp_increase),
        .exp_decrease (exp_decrease),
        .ovf5         (ovf5),
        .ex_time      (ex_time),
        .timer_clr    (timer_clr),
        .timer_start  (timer_start),
        .erase        (erase),
        .expose       (expose),
        .nre_1        (nre_1),
        .nre_2        (nre_2),
        .adc          (adc),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pulse_inc();
        exp_increase = 1'b1; tick();
        exp_increase = 1'b0; tick();
    endtask

    task automatic pulse_dec();
        exp_decrease = 1'b1; tick();
        exp_decrease = 1'b0; tick();
    endtask

    // init pulse through READ s0; leaves the DUT in READ step 0
    task automatic capture_to_s0();
        init = 1'b1; tick();
        check("arm", w_outs, C_O_ARM);
        init = 1'b0; tick();
        check("expose_first", w_outs, C_O_EXP1);
        tick();
        check("expose_second", w_outs, C_O_EXP);
        ovf5 = 1'b1; tick();
        ovf5 = 1'b0;
        check("read_s0", w_outs, c_read[0]);
    endtask

    initial begin
        c_read[0] = 8'b0001_0100;
        c_read[1] = 8'b0001_1100;
        c_read[2] = 8'b0001_0100;
        c_read[3] = 8'b0011_0100;
        c_read[4] = 8'b0010_0100;
        c_read[5] = 8'b0010_1100;
        c_read[6] = 8'b0010_0100;
        c_read[7] = 8'b0011_0100;

        reset = 1'b1; init = 1'b0; exp_increase = 1'b0; exp_decrease = 1'b0; ovf5 = 1'b0;
        tick(); tick(); tick();
        check("reset_outs", w_outs, C_O_IDLE);
        check("reset_ex_time", {3'b0, ex_time}, 8'd15);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_outs", w_outs, C_O_IDLE);
        check("idle_ex_time", {3'b0, ex_time}, 8'd15);

        // Exposure adjust and saturation
        pulse_inc();
        check("inc_one", {3'b0, ex_time}, 8'd16);
        repeat (19) pulse_inc();
        check("inc_sat", {3'b0, ex_time}, 8'd30);
        pulse_dec();
        check("dec_one", {3'b0, ex_time}, 8'd29);
        repeat (39) pulse_dec();
        check("dec_sat", {3'b0, ex_time}, 8'd2);
        exp_increase = 1'b1; exp_decrease = 1'b1; tick();
        exp_increase = 1'b0; exp_decrease = 1'b0; tick();
        check("both_edges", {3'b0, ex_time}, 8'd2);
        repeat (3) pulse_inc();
        check("set_five", {3'b0, ex_time}, 8'd5);

        // Full capture, with adjust presses during EXPOSE that must be dropped
        init = 1'b1; tick();
        check("cap_arm", w_outs, C_O_ARM);
        init = 1'b0; tick();
        check("cap_expose_first", w_outs, C_O_EXP1);
        exp_increase = 1'b1; tick();
        check("cap_expose_2", w_outs, C_O_EXP);
        exp_increase = 1'b0; exp_decrease = 1'b1; tick();
        check("cap_expose_3", w_outs, C_O_EXP);
        exp_decrease = 1'b0; tick(); tick(); tick();
        check("cap_expose_6", w_outs, C_O_EXP);
        ovf5 = 1'b1; tick();
        ovf5 = 1'b0;
        check("cap_s0", w_outs, c_read[0]);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("cap_s%0d", i), w_outs, c_read[i]);
        end
        tick();
        check("cap_idle", w_outs, C_O_IDLE);
        check("cap_ex_time", {3'b0, ex_time}, 8'd5);

        // ovf5 ignored on first EXPOSE cycle, then reset mid-EXPOSE
        init = 1'b1; tick();
        init = 1'b0; tick();
        check("ign_expose_first", w_outs, C_O_EXP1);
        ovf5 = 1'b1; tick();
        check("ign_ovf_first", w_outs, C_O_EXP);
        ovf5 = 1'b0; reset = 1'b1; tick();
        check("rst_expose_outs", w_outs, C_O_IDLE);
        check("rst_expose_ex_time", {3'b0, ex_time}, 8'd15);
        reset = 1'b0; tick();

        // Reset at READ step 5
        capture_to_s0();
        repeat (5) tick();
        check("pre_rst_s5", w_outs, c_read[5]);
        reset = 1'b1; tick();
        check("rst_read_outs", w_outs, C_O_IDLE);
        check("rst_read_ex_time", {3'b0, ex_time}, 8'd15);
        reset = 1'b0; tick();

        // init held high across an entire capture
        init = 1'b1; tick();
        check("hold_arm", w_outs, C_O_ARM);
        tick();
        check("hold_expose_first", w_outs, C_O_EXP1);
        ovf5 = 1'b1; tick(); tick();
        ovf5 = 1'b0;
        check("hold_s0", w_outs, c_read[0]);
        repeat (7) tick();
        check("hold_s7", w_outs, c_read[7]);
        tick();
`ifdef CAM_CONT_EN
        check("cont_rearm", w_outs, C_O_ARM);
        tick();
        check("cont_expose_first", w_outs, C_O_EXP1);
`else
        check("hold_idle", w_outs, C_O_IDLE);
        tick(); tick();
        check("hold_no_retrigger", w_outs, C_O_IDLE);
        init = 1'b0; tick();
        init = 1'b1; tick();
        check("hold_new_edge_arm", w_outs, C_O_ARM);
`endif
        init = 1'b0;
        reset = 1'b1; tick();
        check("final_reset", w_outs, C_O_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
